fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end: the reader side of the program-counter/instruction-memory path.
//  Generates sequential fetch addresses into the synchronous instruction ROM (1-cycle read latency).
//  Buffers returned words with their address in a small FIFO; hands them to decode via valid/ready.
//  Redirects on taken branches (BRZ/BRN resolved downstream), flushing all stale fetches.
// PARAMETERS
//  IW     9  instruction word width
//  AW     8  address width (PC range 0..2^AW-1)
//  DEPTH  2  FIFO entries (>=2); queued plus in-flight never exceeds DEPTH
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset        in   1   asynchronous, active-high; clears all state
//  redirect     in   1   taken branch this cycle; flush and refetch from redirect_pc
//  redirect_pc  in   AW  branch target (already PC + bamt, computed upstream)
//  imem_req     out  1   ROM read request this cycle
//  imem_addr    out  AW  ROM read address (valid when imem_req)
//  imem_data    in   IW  ROM data, valid the cycle after the matching imem_req
//  inst_valid   out  1   head entry available to decode
//  inst_ready   in   1   decode accepts head entry
//  inst         out  IW  head instruction word
//  inst_pc      out  AW  address the head instruction was fetched from
// BEHAVIOUR
//  Reset (async): fetch_pc=0, count=0, inflight=0, drop=0.
//   Outputs after reset: imem_req=0, inst_valid=0, inst=0, inst_pc=0.
//  Issue: imem_req = !reset && !redirect && (count + inflight - pop) < DEPTH.
//   pop = inst_valid & inst_ready. imem_addr = fetch_pc.
//   fetch_pc increments by 1 on issue, mod 2^AW (e.g. 255 -> 0).
//  Response: inflight=1 marks an outstanding read. Next cycle imem_data is written to the tail
//   together with its address, unless drop=1 or redirect=1 in that response cycle.
//  Output: inst_valid = (count != 0). inst/inst_pc are driven from the head entry (registered storage).
//   Head is held stable while inst_valid && !inst_ready.
//  Latency: req in cycle N -> data in N+1 -> inst_valid in N+2.
//   Throughput is 1 instr/cycle with inst_ready held high.
//  Simultaneous pop + write: count unchanged; FIFO pointers wrap mod DEPTH.
//  Full: count + inflight == DEPTH with no pop -> imem_req=0. No entry is ever overwritten.
//  Empty: inst_valid=0; inst/inst_pc hold their last values and carry no meaning.
//  Redirect (cycle R): count <= 0; fetch_pc <= redirect_pc; no request in R.
//   A response arriving in R is discarded.
//   A request issued in R-1 is marked drop; it is discarded on arrival in R, and drop clears.
//   A pop in R completes normally from decode's view; the rest of the FIFO is flushed.
//   R+1: imem_req=1, imem_addr=redirect_pc. R+3: inst_valid=1, inst_pc=redirect_pc.
//  Back-to-back redirects: last one wins; each flushes what precedes it.
//  Reset mid-operation: all state returns to reset values immediately; in-flight data is ignored.
// TESTING
//  1. Reset release, ROM[i]=i+9'h100, ready=1 -> reqs at addr 0,1,2... each cycle.
//     inst_valid from cycle 3 on, inst_pc=0,1,2 consecutively, no gaps.
//  2. inst_ready=0 for 5 cycles after first valid -> exactly 2 reqs outstanding/queued, imem_req=0.
//     Head stays inst_pc=0. After release, inst_pc=0,1,2 with no skip or duplicate.
//  3. redirect=1, redirect_pc=8'h40 while FIFO full and a read in flight -> inst_valid=0 at R+1, R+2.
//     imem_addr=8'h40 at R+1. First delivered inst_pc=8'h40 at R+3; no stale address ever delivered.
//  4. redirect in two consecutive cycles, targets 8'h10 then 8'h20 -> 8'h10 never delivered.
//     First inst_pc is 8'h20.
//  5. redirect_pc=8'hFE, ready=1 -> delivered inst_pc sequence FE, FF, 00, 01.
//  6. Assert reset for 1 cycle mid-stream with FIFO full -> inst_valid=0 and imem_req=0 immediately.
//     Refetch restarts at address 0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: redirect input, instruction-ROM read port and decode handshake.
// The master side belongs to fetch_queue; the slave side is the ROM/decode environment.
interface fetch_queue_if #(
   parameter int IW = 9,
   parameter int AW = 8
);
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_data;
   logic          inst_valid;
   logic          inst_ready;
   logic [IW-1:0] inst;
   logic [AW-1:0] inst_pc;

   modport master (
      input  redirect, redirect_pc, imem_data, inst_ready,
      output imem_req, imem_addr, inst_valid, inst, inst_pc
   );

   modport slave (
      output redirect, redirect_pc, imem_data, inst_ready,
      input  imem_req, imem_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential ROM reads, buffers words with their PC
// and hands them to decode over valid/ready; a taken branch flushes and refetches.
module fetch_queue #(
   parameter int IW    = 9,
   parameter int AW    = 8,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.master bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic          inflight_q, inflight_d;
   logic          drop_q, drop_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [IW-1:0] word_q [DEPTH];
   logic [AW-1:0] addr_q [DEPTH];

   logic          pop;
   logic          push;
   logic          issue;
   logic [CW:0]   occupancy;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      return p + 1'b1;
   endfunction

   always_comb begin
      pop        = (count_q != '0) && bus.inst_ready;
      // Queued plus in-flight words may never exceed DEPTH, crediting this cycle's pop.
      occupancy  = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
      issue      = !reset && !bus.redirect && (occupancy < (CW + 1)'(DEPTH));
      push       = inflight_q && !drop_q && !bus.redirect;

      inflight_d = issue;
      drop_d     = bus.redirect && issue;
      rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      fetch_pc_d = issue ? fetch_pc_q + 1'b1 : fetch_pc_q;

      // The pop still completes; everything behind it is flushed.
      if (bus.redirect) begin
         count_d    = '0;
         wr_ptr_d   = rd_ptr_d;
         fetch_pc_d = bus.redirect_pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         if (push) begin
            // The in-flight address is the PC one behind fetch_pc.
            word_q[wr_ptr_q] <= bus.imem_data;
            addr_q[wr_ptr_q] <= fetch_pc_q - 1'b1;
         end
      end
   end

   assign bus.imem_req   = issue;
   assign bus.imem_addr  = fetch_pc_q;
   assign bus.inst_valid = (count_q != '0);
   assign bus.inst       = word_q[rd_ptr_q];
   assign bus.inst_pc    = addr_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a per-cycle vector table plus a redirect-latency sequence.
module tb_fetch_queue;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   passed = 0;
   int   total = 0;

   fetch_queue_if #(.IW(9), .AW(8)) ifc ();

   fetch_queue #(.IW(9), .AW(8), .DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   // Synchronous ROM model: ROM[a] = 9'h100 + a, one-cycle read latency.
   always @(posedge clk) begin
      if (ifc.imem_req) ifc.imem_data <= {1'b1, ifc.imem_addr};
   end

   typedef struct {
      logic       rst;
      logic       redir;
      logic [7:0] rpc;
      logic       rdy;
      logic       req;
      logic [7:0] addr;
      logic       vld;
      logic [7:0] ipc;
   } vec_t;

   vec_t tbl[$];

   task automatic v(input logic rst, input logic redir, input logic [7:0] rpc, input logic rdy,
                    input logic req, input logic [7:0] addr, input logic vld, input logic [7:0] ipc);
      vec_t e;
      e.rst = rst; e.redir = redir; e.rpc = rpc; e.rdy = rdy;
      e.req = req; e.addr = addr; e.vld = vld; e.ipc = ipc;
      tbl.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      ifc.redirect    = 1'b0;
      ifc.redirect_pc = '0;
      ifc.inst_ready  = 1'b1;

      // rst redir rpc rdy | req addr vld ipc
      v(1,0,8'h00,1, 0,8'h00,0,8'h00);
      // sequential streaming from address 0
      v(0,0,8'h00,1, 1,8'h00,0,8'h00);
      v(0,0,8'h00,1, 1,8'h01,0,8'h00);
      v(0,0,8'h00,1, 1,8'h02,1,8'h00);
      v(0,0,8'h00,1, 1,8'h03,1,8'h01);
      v(0,0,8'h00,1, 1,8'h04,1,8'h02);
      v(0,0,8'h00,1, 1,8'h05,1,8'h03);
      // decode stall fills the queue; head must hold at PC 0
      v(1,0,8'h00,1, 0,8'h00,0,8'h00);
      v(0,0,8'h00,1, 1,8'h00,0,8'h00);
      v(0,0,8'h00,1, 1,8'h01,0,8'h00);
      for (int i = 0; i < 5; i++) v(0,0,8'h00,0, 0,8'h02,1,8'h00);
      v(0,0,8'h00,1, 1,8'h02,1,8'h00);
      v(0,0,8'h00,1, 1,8'h03,1,8'h01);
      v(0,0,8'h00,1, 1,8'h04,1,8'h02);
      v(0,0,8'h00,1, 1,8'h05,1,8'h03);
      // redirect to 0x40 with a queued word and a read in flight
      v(0,1,8'h40,0, 0,8'h06,1,8'h04);
      v(0,0,8'h00,1, 1,8'h40,0,8'h00);
      v(0,0,8'h00,1, 1,8'h41,0,8'h00);
      v(0,0,8'h00,1, 1,8'h42,1,8'h40);
      v(0,0,8'h00,1, 1,8'h43,1,8'h41);
      // redirect near the top of the address space, PC wraps
      v(0,1,8'hFE,1, 0,8'h44,1,8'h42);
      v(0,0,8'h00,1, 1,8'hFE,0,8'h00);
      v(0,0,8'h00,1, 1,8'hFF,0,8'h00);
      v(0,0,8'h00,1, 1,8'h00,1,8'hFE);
      v(0,0,8'h00,1, 1,8'h01,1,8'hFF);
      v(0,0,8'h00,1, 1,8'h02,1,8'h00);
      v(0,0,8'h00,1, 1,8'h03,1,8'h01);
      // back-to-back redirects: 0x10 is superseded by 0x20
      v(0,1,8'h10,1, 0,8'h04,1,8'h02);
      v(0,1,8'h20,1, 0,8'h10,0,8'h00);
      v(0,0,8'h00,1, 1,8'h20,0,8'h00);
      v(0,0,8'h00,1, 1,8'h21,0,8'h00);
      v(0,0,8'h00,1, 1,8'h22,1,8'h20);
      v(0,0,8'h00,1, 1,8'h23,1,8'h21);
      // fill the queue, then reset mid-stream
      v(0,0,8'h00,0, 0,8'h24,1,8'h22);
      v(0,0,8'h00,0, 0,8'h24,1,8'h22);
      v(1,0,8'h00,0, 0,8'h00,0,8'h00);
      v(0,0,8'h00,1, 1,8'h00,0,8'h00);
      v(0,0,8'h00,1, 1,8'h01,0,8'h00);
      v(0,0,8'h00,1, 1,8'h02,1,8'h00);
      v(0,0,8'h00,1, 1,8'h03,1,8'h01);

      foreach (tbl[k]) begin
         @(negedge clk);
         reset           = tbl[k].rst;
         ifc.redirect    = tbl[k].redir;
         ifc.redirect_pc = tbl[k].rpc;
         ifc.inst_ready  = tbl[k].rdy;
         #1;
         chk($sformatf("v%0d_req", k), 32'(ifc.imem_req), 32'(tbl[k].req));
         chk($sformatf("v%0d_addr", k), 32'(ifc.imem_addr), 32'(tbl[k].addr));
         chk($sformatf("v%0d_valid", k), 32'(ifc.inst_valid), 32'(tbl[k].vld));
         if (tbl[k].vld) begin
            chk($sformatf("v%0d_pc", k), 32'(ifc.inst_pc), 32'(tbl[k].ipc));
            chk($sformatf("v%0d_inst", k), 32'(ifc.inst), 32'({1'b1, tbl[k].ipc}));
         end
         if (tbl[k].rst) begin
            chk($sformatf("v%0d_rst_inst", k), 32'(ifc.inst), 32'h0);
            chk($sformatf("v%0d_rst_pc", k), 32'(ifc.inst_pc), 32'h0);
         end
      end

      // Redirect to 0x7F: request at R+1, first delivery at R+3.
      @(negedge clk);
      ifc.redirect    = 1'b1;
      ifc.redirect_pc = 8'h7F;
      ifc.inst_ready  = 1'b1;
      @(negedge clk);
      ifc.redirect = 1'b0;
      #1;
      chk("redir_req", 32'(ifc.imem_req), 32'h1);
      chk("redir_addr", 32'(ifc.imem_addr), 32'h7F);
      chk("redir_gap", 32'(ifc.inst_valid), 32'h0);
      n = 1;
      while (!ifc.inst_valid && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("redir_latency", 32'(n), 32'd3);
      chk("redir_pc", 32'(ifc.inst_pc), 32'h7F);
      chk("redir_inst", 32'(ifc.inst), 32'h17F);
      @(negedge clk);
      #1;
      chk("redir_next_pc", 32'(ifc.inst_pc), 32'h80);
      chk("redir_next_vld", 32'(ifc.inst_valid), 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
